// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_arb_pkg
//  Description : Shared types and constants for the two-requester SDRAM
//                Avalon-MM arbiter: requester ids, FSM state encoding,
//                debug_flag bit positions and a pending-count saturator.
//  Revision    : 1.0  initial release
// ============================================================================
package sdram_arb_pkg;

    localparam logic REQ_PCIE = 1'b0;
    localparam logic REQ_USER = 1'b1;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int DBG_RSP_ERR    = 15;
    localparam int DBG_PEND_HI    = 14;
    localparam int DBG_PEND_LO    = 12;
    localparam int DBG_LAST_GRANT = 11;
    localparam int DBG_BUSY       = 10;
    localparam int DBG_TXN_HI     = 9;
    localparam int DBG_TXN_LO     = 0;

    // Pending count squeezed into the 3-bit debug field.
    function automatic logic [2:0] sat_pend(input logic [7:0] cnt);
        return (cnt > 8'd7) ? 3'd7 : cnt[2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : arb_tag_fifo
//  Description : Synchronous 1-bit-wide in-order FIFO holding the requester
//                id of each issued read. Depth must be a power of two so the
//                pointers wrap naturally. Push and pop in the same cycle are
//                legal while non-empty (count unchanged).
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                push_i/push_id_i  - write one id
//                pop_i             - discard head
//                head_o            - id at the head
//                full_o/empty_o    - status
//                count_o           - entries held
//  Revision    : 1.0  initial release
// ============================================================================
module arb_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     push_id_i,
    input  logic                     pop_i,
    output logic                     head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only allowed when the head leaves this cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_id_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_avmm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_avmm_arbiter
//  Description : Round-robin Avalon-MM arbiter sharing one SDRAM controller
//                slave between the PCIe bridge (m0) and the user module (m1).
//                Commands are registered onto av_*; read responses are routed
//                back through an in-order tag FIFO.
//  Ports       : clk, reset               - clock, sync active-high reset
//                m0_* / m1_*              - Avalon-MM slave ports per requester
//                av_*                     - Avalon-MM master to SDRAM controller
//                debug_flag               - {rsp_err, pending, last_grant,
//                                            busy, txn_cnt[9:0]}
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_avmm_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W   = 23,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [3:0]        m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [3:0]        m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] av_address,
    output logic              av_read,
    output logic              av_write,
    output logic [DATA_W-1:0] av_writedata,
    output logic [3:0]        av_byteenable,
    input  logic              av_waitrequest,
    input  logic [DATA_W-1:0] av_readdata,
    input  logic              av_readdatavalid,
    output logic [15:0]       debug_flag
);

    localparam int CNT_W = $clog2(MAX_PEND) + 1;

    arb_state_e        state_q;
    logic              grant_q;
    logic              last_grant_q;
    logic [ADDR_W-1:0] av_address_q;
    logic              av_read_q;
    logic              av_write_q;
    logic [DATA_W-1:0] av_writedata_q;
    logic [3:0]        av_byteenable_q;
    logic [9:0]        txn_cnt_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] m0_readdata_q;
    logic [DATA_W-1:0] m1_readdata_q;
    logic              m0_rvalid_q;
    logic              m1_rvalid_q;

    logic              elig0;
    logic              elig1;
    logic              cand;
    logic              accept;
    logic              tag_push;
    logic              tag_pop;
    logic              tag_head;
    logic              tag_full;
    logic              tag_empty;
    logic [CNT_W-1:0]  tag_count;

    // A read is eligible only while the FIFO has room for its tag; the count
    // is exact in IDLE because no command is in flight then.
    always_comb begin
        elig0 = m0_write | (m0_read & ~tag_full);
        elig1 = m1_write | (m1_read & ~tag_full);
        if (elig0 & elig1) begin
            cand = ~last_grant_q;
        end else if (elig1) begin
            cand = REQ_USER;
        end else begin
            cand = REQ_PCIE;
        end
    end

    // Reset is folded in so no requester sees an accept while in reset.
    assign accept         = (state_q == ARB_IDLE) & (elig0 | elig1) & ~reset;
    assign m0_waitrequest = ~(accept & (cand == REQ_PCIE));
    assign m1_waitrequest = ~(accept & (cand == REQ_USER));

    assign tag_push = (state_q == ARB_BUSY) & ~av_waitrequest & av_read_q;
    assign tag_pop  = av_readdatavalid & ~tag_empty;

    arb_tag_fifo #(
        .DEPTH (MAX_PEND)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (tag_push),
        .push_id_i (grant_q),
        .pop_i     (tag_pop),
        .head_o    (tag_head),
        .full_o    (tag_full),
        .empty_o   (tag_empty),
        .count_o   (tag_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ARB_IDLE;
            grant_q         <= REQ_PCIE;
            last_grant_q    <= REQ_USER;
            av_address_q    <= '0;
            av_read_q       <= 1'b0;
            av_write_q      <= 1'b0;
            av_writedata_q  <= '0;
            av_byteenable_q <= '0;
            txn_cnt_q       <= '0;
            rsp_err_q       <= 1'b0;
            m0_readdata_q   <= '0;
            m1_readdata_q   <= '0;
            m0_rvalid_q     <= 1'b0;
            m1_rvalid_q     <= 1'b0;
        end else begin
            // Response path: one-cycle registered steering by FIFO head.
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            if (tag_pop) begin
                if (tag_head == REQ_PCIE) begin
                    m0_readdata_q <= av_readdata;
                    m0_rvalid_q   <= 1'b1;
                end else begin
                    m1_readdata_q <= av_readdata;
                    m1_rvalid_q   <= 1'b1;
                end
            end
            if (av_readdatavalid & tag_empty) begin
                rsp_err_q <= 1'b1;
            end

            case (state_q)
                ARB_IDLE: begin
                    if (accept) begin
                        if (cand == REQ_USER) begin
                            av_address_q    <= m1_address;
                            av_read_q       <= m1_read;
                            av_write_q      <= m1_write;
                            av_writedata_q  <= m1_writedata;
                            av_byteenable_q <= m1_byteenable;
                        end else begin
                            av_address_q    <= m0_address;
                            av_read_q       <= m0_read;
                            av_write_q      <= m0_write;
                            av_writedata_q  <= m0_writedata;
                            av_byteenable_q <= m0_byteenable;
                        end
                        grant_q      <= cand;
                        last_grant_q <= cand;
                        state_q      <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (!av_waitrequest) begin
                        av_read_q  <= 1'b0;
                        av_write_q <= 1'b0;
                        txn_cnt_q  <= txn_cnt_q + 10'd1;
                        state_q    <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign av_address       = av_address_q;
    assign av_read          = av_read_q;
    assign av_write         = av_write_q;
    assign av_writedata     = av_writedata_q;
    assign av_byteenable    = av_byteenable_q;
    assign m0_readdata      = m0_readdata_q;
    assign m1_readdata      = m1_readdata_q;
    assign m0_readdatavalid = m0_rvalid_q;
    assign m1_readdatavalid = m1_rvalid_q;

    assign debug_flag[DBG_RSP_ERR]             = rsp_err_q;
    assign debug_flag[DBG_PEND_HI:DBG_PEND_LO] = sat_pend(8'(tag_count));
    assign debug_flag[DBG_LAST_GRANT]          = last_grant_q;
    assign debug_flag[DBG_BUSY]                = (state_q == ARB_BUSY);
    assign debug_flag[DBG_TXN_HI:DBG_TXN_LO]   = txn_cnt_q;

endmodule
`default_nettype wire
